fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer for the word-addressed instruction ROM (combinational read, base 0x0040_0024).

---
 rtl/fetch_ctrl_if.sv | 27 ++
 rtl/fetch_ctrl.sv | 111 +++++++++++
 tb/tb_fetch_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Fetch sequencer bus: ROM address/data, decode valid/ready slot, redirect/halt control and status.
interface fetch_ctrl_if;
  logic [31:0] pc_o;
  logic [31:0] rom_inst_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        halt_i;
  logic        halted_o;
  logic        fetch_err_o;
  logic [31:0] inst_cnt_o;

  // Fetch controller side
  modport master (
    output pc_o, inst_o, inst_pc_o, inst_valid_o, halted_o, fetch_err_o, inst_cnt_o,
    input  rom_inst_i, inst_ready_i, redirect_i, redirect_pc_i, halt_i
  );

  // ROM / decode / control side
  modport slave (
    input  pc_o, inst_o, inst_pc_o, inst_valid_o, halted_o, fetch_err_o, inst_cnt_o,
    output rom_inst_i, inst_ready_i, redirect_i, redirect_pc_i, halt_i
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches from a combinational ROM into a
// one-entry valid/ready slot, handles redirects, halt/resume and sticky range errors.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0024,
  parameter int unsigned ROM_DEPTH = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_ctrl_if.master bus
);

  localparam logic [31:0] WIN_BYTES = 32'(4 * ROM_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, HALT, ERR} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        halted;
  logic        fetch_err;
  logic [31:0] inst_cnt;
  logic        adv;
  logic        accept;

  // Word-aligned and inside the ROM window; unsigned wrap makes addresses below base fail.
  function automatic logic in_range(input logic [31:0] p);
    return (p[1:0] == 2'b00) && ((p - RESET_PC) < WIN_BYTES);
  endfunction

  assign adv    = !inst_valid || bus.inst_ready_i;
  assign accept = inst_valid && bus.inst_ready_i;

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
      halted     <= 1'b0;
      fetch_err  <= 1'b0;
      inst_cnt   <= '0;
    end else begin
      // An accepted word counts even when a redirect flushes the slot this cycle.
      if (accept && state != ERR) inst_cnt <= inst_cnt + 32'd1;

      case (state)
        IDLE: state <= RUN;

        RUN: begin
          if (bus.redirect_i) begin
            inst_valid <= 1'b0;
            if (in_range(bus.redirect_pc_i)) begin
              pc <= bus.redirect_pc_i;
            end else begin
              state     <= ERR;
              fetch_err <= 1'b1;
            end
          end else if (bus.halt_i) begin
            state  <= HALT;
            halted <= 1'b1;
            if (accept) inst_valid <= 1'b0;
          end else if (adv) begin
            if (in_range(pc)) begin
              inst       <= bus.rom_inst_i;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
              pc         <= pc + 32'd4;
            end else begin
              state      <= ERR;
              fetch_err  <= 1'b1;
              inst_valid <= 1'b0;
            end
          end
        end

        HALT: begin
          if (accept) inst_valid <= 1'b0;
          if (bus.redirect_i) begin
            inst_valid <= 1'b0;
            halted     <= 1'b0;
            if (in_range(bus.redirect_pc_i)) begin
              state <= RUN;
              pc    <= bus.redirect_pc_i;
            end else begin
              state     <= ERR;
              fetch_err <= 1'b1;
            end
          end
        end

        ERR: begin
          inst_valid <= 1'b0;
          fetch_err  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.pc_o         = pc;
  assign bus.inst_o       = inst;
  assign bus.inst_pc_o    = inst_pc;
  assign bus.inst_valid_o = inst_valid;
  assign bus.halted_o     = halted;
  assign bus.fetch_err_o  = fetch_err;
  assign bus.inst_cnt_o   = inst_cnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl with a 64-word ROM model at 0x0040_0024.
module tb_fetch_ctrl;

  localparam logic [31:0] BASE = 32'h0040_0024;

  logic clk = 1'b0;
  logic rst_n;
  int   vec = 0;
  int   mis = 0;
  logic [31:0] rom [64];
  logic [31:0] off;

  fetch_ctrl_if bus ();

  fetch_ctrl #(.RESET_PC(BASE), .ROM_DEPTH(64)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Combinational ROM; out-of-window reads return a poison word.
  always_comb begin
    off = bus.pc_o - BASE;
    if (off < 32'd256 && bus.pc_o[1:0] == 2'b00) bus.rom_inst_i = rom[off[7:2]];
    else                                          bus.rom_inst_i = 32'hDEAD_BEEF;
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.inst_ready_i = 1'b0;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = '0;
    bus.halt_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    apply_reset();
    vec++; if (bus.pc_o !== BASE) begin mis++; $display("FAIL reset_pc got %h exp %h", bus.pc_o, BASE); end
    vec++; if (bus.inst_valid_o !== 1'b0) begin mis++; $display("FAIL reset_valid got %b exp 0", bus.inst_valid_o); end
    vec++; if (bus.inst_o !== 32'h0 || bus.inst_pc_o !== 32'h0) begin mis++; $display("FAIL reset_inst got %h/%h exp 0/0", bus.inst_o, bus.inst_pc_o); end
    vec++; if (bus.inst_cnt_o !== 32'h0 || bus.halted_o !== 1'b0 || bus.fetch_err_o !== 1'b0) begin
      mis++; $display("FAIL reset_status cnt %0d halted %b err %b exp 0/0/0", bus.inst_cnt_o, bus.halted_o, bus.fetch_err_o); end
  endtask

  // Scenario 1: first word two cycles after release, then one per cycle.
  task automatic test_stream();
    bus.inst_ready_i = 1'b1;
    @(negedge clk);
    vec++; if (bus.inst_valid_o !== 1'b0) begin mis++; $display("FAIL idle_valid got %b exp 0", bus.inst_valid_o); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vec++;
      if (bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== BASE + 32'(4 * i) || bus.inst_o !== rom[i] || bus.inst_cnt_o !== 32'(i)) begin
        mis++; $display("FAIL stream_%0d got v=%b pc=%h inst=%h cnt=%0d exp v=1 pc=%h inst=%h cnt=%0d",
                        i, bus.inst_valid_o, bus.inst_pc_o, bus.inst_o, bus.inst_cnt_o, BASE + 32'(4 * i), rom[i], i);
      end
    end
  endtask

  // Scenario 2: backpressure freezes the slot and PC, then resumes without gaps.
  task automatic test_stall();
    bus.inst_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vec++;
      if (bus.inst_pc_o !== BASE + 32'd20 || bus.inst_o !== rom[5] || bus.pc_o !== BASE + 32'd24 || bus.inst_cnt_o !== 32'd5) begin
        mis++; $display("FAIL stall_%0d got ipc=%h inst=%h pc=%h cnt=%0d exp ipc=%h inst=%h pc=%h cnt=5",
                        i, bus.inst_pc_o, bus.inst_o, bus.pc_o, bus.inst_cnt_o, BASE + 32'd20, rom[5], BASE + 32'd24);
      end
    end
    bus.inst_ready_i = 1'b1;
    for (int i = 6; i < 8; i++) begin
      @(negedge clk);
      vec++;
      if (bus.inst_pc_o !== BASE + 32'(4 * i) || bus.inst_o !== rom[i] || bus.inst_cnt_o !== 32'(i)) begin
        mis++; $display("FAIL resume_%0d got ipc=%h inst=%h cnt=%0d exp ipc=%h inst=%h cnt=%0d",
                        i, bus.inst_pc_o, bus.inst_o, bus.inst_cnt_o, BASE + 32'(4 * i), rom[i], i);
      end
    end
  endtask

  // Scenario 3: redirect while the slot is held flushes it without counting it.
  task automatic test_redirect();
    bus.inst_ready_i = 1'b0;
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h0040_0040;
    @(negedge clk);
    bus.redirect_i = 1'b0;
    bus.inst_ready_i = 1'b1;
    vec++; if (bus.inst_valid_o !== 1'b0 || bus.inst_cnt_o !== 32'd7) begin
      mis++; $display("FAIL redir_flush got v=%b cnt=%0d exp v=0 cnt=7", bus.inst_valid_o, bus.inst_cnt_o); end
    @(negedge clk);
    vec++; if (bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== 32'h0040_0040 || bus.inst_o !== rom[7] || bus.inst_cnt_o !== 32'd7) begin
      mis++; $display("FAIL redir_target got v=%b ipc=%h inst=%h cnt=%0d exp v=1 ipc=00400040 inst=%h cnt=7",
                      bus.inst_valid_o, bus.inst_pc_o, bus.inst_o, bus.inst_cnt_o, rom[7]); end
  endtask

  // Scenario 6: halt, halt release alone does not resume, redirect resumes, reset mid-run.
  task automatic test_halt();
    bus.halt_i = 1'b1;
    @(negedge clk);
    vec++; if (bus.halted_o !== 1'b1 || bus.inst_valid_o !== 1'b0 || bus.inst_cnt_o !== 32'd8 || bus.pc_o !== 32'h0040_0044) begin
      mis++; $display("FAIL halt_enter got h=%b v=%b cnt=%0d pc=%h exp h=1 v=0 cnt=8 pc=00400044",
                      bus.halted_o, bus.inst_valid_o, bus.inst_cnt_o, bus.pc_o); end
    bus.halt_i = 1'b0;
    repeat (3) @(negedge clk);
    vec++; if (bus.halted_o !== 1'b1 || bus.inst_valid_o !== 1'b0 || bus.inst_cnt_o !== 32'd8 || bus.pc_o !== 32'h0040_0044) begin
      mis++; $display("FAIL halt_hold got h=%b v=%b cnt=%0d pc=%h exp h=1 v=0 cnt=8 pc=00400044",
                      bus.halted_o, bus.inst_valid_o, bus.inst_cnt_o, bus.pc_o); end
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h0040_0030;
    @(negedge clk);
    bus.redirect_i = 1'b0;
    vec++; if (bus.halted_o !== 1'b0 || bus.inst_valid_o !== 1'b0 || bus.pc_o !== 32'h0040_0030) begin
      mis++; $display("FAIL halt_resume got h=%b v=%b pc=%h exp h=0 v=0 pc=00400030", bus.halted_o, bus.inst_valid_o, bus.pc_o); end
    @(negedge clk);
    vec++; if (bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== 32'h0040_0030 || bus.inst_o !== rom[3] || bus.inst_cnt_o !== 32'd8) begin
      mis++; $display("FAIL halt_fetch got v=%b ipc=%h inst=%h cnt=%0d exp v=1 ipc=00400030 inst=%h cnt=8",
                      bus.inst_valid_o, bus.inst_pc_o, bus.inst_o, bus.inst_cnt_o, rom[3]); end
    @(negedge clk);
    apply_reset();
    vec++; if (bus.pc_o !== BASE || bus.inst_valid_o !== 1'b0 || bus.inst_cnt_o !== 32'd0 || bus.inst_o !== 32'd0 || bus.inst_pc_o !== 32'd0) begin
      mis++; $display("FAIL midrun_reset got pc=%h v=%b cnt=%0d inst=%h ipc=%h exp pc=%h v=0 cnt=0 inst=0 ipc=0",
                      bus.pc_o, bus.inst_valid_o, bus.inst_cnt_o, bus.inst_o, bus.inst_pc_o, BASE); end
  endtask

  // Scenario 4: sequential fetch off the end of the ROM window latches a sticky error.
  task automatic test_end_of_rom();
    apply_reset();
    bus.inst_ready_i = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (i == 0 || i == 63) begin
        vec++;
        if (bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== BASE + 32'(4 * i) || bus.inst_o !== rom[i]) begin
          mis++; $display("FAIL seq_%0d got v=%b ipc=%h inst=%h exp v=1 ipc=%h inst=%h",
                          i, bus.inst_valid_o, bus.inst_pc_o, bus.inst_o, BASE + 32'(4 * i), rom[i]);
        end
      end
    end
    @(negedge clk);
    vec++; if (bus.fetch_err_o !== 1'b1 || bus.inst_valid_o !== 1'b0 || bus.inst_cnt_o !== 32'd64 || bus.pc_o !== 32'h0040_0124) begin
      mis++; $display("FAIL end_err got err=%b v=%b cnt=%0d pc=%h exp err=1 v=0 cnt=64 pc=00400124",
                      bus.fetch_err_o, bus.inst_valid_o, bus.inst_cnt_o, bus.pc_o); end
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h0040_0030;
    repeat (3) @(negedge clk);
    bus.redirect_i = 1'b0;
    vec++; if (bus.fetch_err_o !== 1'b1 || bus.inst_valid_o !== 1'b0 || bus.pc_o !== 32'h0040_0124 || bus.inst_cnt_o !== 32'd64) begin
      mis++; $display("FAIL err_sticky got err=%b v=%b pc=%h cnt=%0d exp err=1 v=0 pc=00400124 cnt=64",
                      bus.fetch_err_o, bus.inst_valid_o, bus.pc_o, bus.inst_cnt_o); end
  endtask

  // Scenario 5: misaligned and below-base redirect targets; only reset clears the error.
  task automatic test_bad_redirect();
    logic [31:0] bad [2];
    bad[0] = 32'h0040_0026;
    bad[1] = 32'h0040_0020;
    for (int k = 0; k < 2; k++) begin
      apply_reset();
      bus.inst_ready_i = 1'b1;
      repeat (3) @(negedge clk);
      bus.redirect_i = 1'b1;
      bus.redirect_pc_i = bad[k];
      @(negedge clk);
      bus.redirect_i = 1'b0;
      vec++; if (bus.fetch_err_o !== 1'b1 || bus.inst_valid_o !== 1'b0 || bus.pc_o !== BASE + 32'd8) begin
        mis++; $display("FAIL bad_redir_%0d got err=%b v=%b pc=%h exp err=1 v=0 pc=%h",
                        k, bus.fetch_err_o, bus.inst_valid_o, bus.pc_o, BASE + 32'd8); end
    end
    apply_reset();
    vec++; if (bus.fetch_err_o !== 1'b0 || bus.halted_o !== 1'b0) begin
      mis++; $display("FAIL err_clear got err=%b h=%b exp 0/0", bus.fetch_err_o, bus.halted_o); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = {16'hC0DE, 8'(i), 8'(8'hFF - 8'(i))};
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_halt();
    test_end_of_rom();
    test_bad_redirect();
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
